// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone N-master arbiter and its picker.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        ABORT   = 2'd2
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arb_picker.sv
// Combinational request picker: lowest index wins in fixed mode, nearest index
// after the pointer (with wrap-around) wins in round-robin mode.
module wb_arb_picker
    import wb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_rr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    int            w_cand;
    logic [IW-1:0] w_k;

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        w_cand  = 0;
        w_k     = '0;
        if (i_rr) begin
            // Walk from the farthest offset inward so the nearest requester overwrites.
            for (int k = N; k >= 1; k--) begin
                w_cand = (int'(i_ptr) + k) % N;
                w_k    = w_cand[IW-1:0];
                if (i_req[w_k]) o_idx = w_k;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                w_k = k[IW-1:0];
                if (i_req[w_k]) o_idx = w_k;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_n_masters.sv
// Wishbone B3 classic arbiter: N masters share one slave port, with fixed-priority
// or round-robin selection, preemption between strobes and a per-strobe watchdog.
module wb_arbiter_n_masters
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ARB_MODE    = 0,
    parameter int PREEMPT     = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_MASTERS-1:0]               i_m_we,
    input  logic [NUM_MASTERS-1:0]               i_m_cyc,
    input  logic [NUM_MASTERS-1:0]               i_m_stb,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  i_m_sel,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    i_m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    i_m_dat,
    output logic [NUM_MASTERS-1:0]               o_m_ack,
    output logic [NUM_MASTERS-1:0]               o_m_err,
    output logic [NUM_MASTERS-1:0]               o_m_int,
    output logic [DATA_WIDTH-1:0]                o_m_dat,
    output logic                                 o_s_we,
    output logic                                 o_s_stb,
    output logic                                 o_s_cyc,
    output logic [DATA_WIDTH/8-1:0]              o_s_sel,
    output logic [ADDR_WIDTH-1:0]                o_s_adr,
    output logic [DATA_WIDTH-1:0]                o_s_dat,
    input  logic [DATA_WIDTH-1:0]                i_s_dat,
    input  logic                                 i_s_ack,
    input  logic                                 i_s_int,
    output logic                                 o_grant_valid,
    output logic [idx_width(NUM_MASTERS)-1:0]    o_grant_idx,
    output logic                                 o_timeout
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int IW    = idx_width(NUM_MASTERS);
    localparam int WD_W  = idx_width(TIMEOUT);

    localparam bit RR_EN      = (ARB_MODE == ARB_RR);
    localparam bit PREEMPT_EN = (ARB_MODE == ARB_FIXED) && (PREEMPT != 0);
    localparam bit WD_EN      = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t             r_state;
    logic                   r_grant_valid;
    logic [IW-1:0]          r_grant_idx;
    logic [IW-1:0]          r_ptr;
    logic [WD_W-1:0]        r_wdog;
    logic                   r_timeout;
    logic [NUM_MASTERS-1:0] r_err;

    logic [ADDR_WIDTH-1:0]  w_adr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  w_dat [NUM_MASTERS];
    logic [SEL_W-1:0]       w_sel [NUM_MASTERS];

    logic                   w_pick_valid;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_granted;
    logic                   w_g_cyc;
    logic                   w_expire;
    logic                   w_preempt;
    logic [NUM_MASTERS-1:0] w_lower_mask;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign w_adr[g] = i_m_adr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_dat[g] = i_m_dat[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_sel[g] = i_m_sel[g*SEL_W +: SEL_W];
    end

    wb_arb_picker #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_picker (
        .i_req   (i_m_cyc),
        .i_ptr   (r_ptr),
        .i_rr    (RR_EN),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_granted = (r_state == GRANTED);
    assign w_g_cyc   = i_m_cyc[r_grant_idx];

    // Slave side is a pure mux of the owner; nothing leaks out in IDLE or ABORT.
    always_comb begin
        o_s_cyc = 1'b0;
        o_s_stb = 1'b0;
        o_s_we  = 1'b0;
        o_s_sel = '0;
        o_s_adr = '0;
        o_s_dat = '0;
        o_m_ack = '0;
        o_m_int = '0;
        if (w_granted) begin
            o_s_cyc              = w_g_cyc;
            o_s_stb              = w_g_cyc & i_m_stb[r_grant_idx];
            o_s_we               = i_m_we[r_grant_idx];
            o_s_sel              = w_sel[r_grant_idx];
            o_s_adr              = w_adr[r_grant_idx];
            o_s_dat              = w_dat[r_grant_idx];
            o_m_ack[r_grant_idx] = i_s_ack;
            o_m_int[r_grant_idx] = i_s_int;
        end
    end

    assign o_m_dat       = i_s_dat;
    assign o_m_err       = r_err;
    assign o_timeout     = r_timeout;
    assign o_grant_valid = r_grant_valid;
    assign o_grant_idx   = r_grant_idx;

    assign w_expire     = WD_EN && o_s_stb && !i_s_ack && (r_wdog == WD_LAST);
    assign w_lower_mask = (NUM_MASTERS'(1) << r_grant_idx) - NUM_MASTERS'(1);
    // Only hand the bus over at an idle point: never between stb and its ack.
    assign w_preempt    = PREEMPT_EN && (|(i_m_cyc & w_lower_mask)) && !o_s_stb && !i_s_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_ptr         <= IW'(NUM_MASTERS - 1);
            r_wdog        <= '0;
            r_timeout     <= 1'b0;
            r_err         <= '0;
        end else begin
            r_timeout <= 1'b0;
            r_err     <= '0;
            case (r_state)
                IDLE: begin
                    r_wdog <= '0;
                    if (w_pick_valid) begin
                        r_state       <= GRANTED;
                        r_grant_valid <= 1'b1;
                        r_grant_idx   <= w_pick_idx;
                        if (RR_EN) r_ptr <= w_pick_idx;
                    end
                end
                GRANTED: begin
                    if (i_s_ack)
                        r_wdog <= '0;
                    else if (o_s_stb)
                        r_wdog <= r_wdog + WD_W'(1);

                    if (!w_g_cyc && !i_s_ack) begin
                        r_state       <= IDLE;
                        r_grant_valid <= 1'b0;
                    end else if (w_expire) begin
                        r_state   <= ABORT;
                        r_wdog    <= '0;
                        r_timeout <= 1'b1;
                        r_err     <= NUM_MASTERS'(1) << r_grant_idx;
                    end else if (w_preempt) begin
                        r_state       <= IDLE;
                        r_grant_valid <= 1'b0;
                    end
                end
                ABORT: begin
                    r_state       <= IDLE;
                    r_grant_valid <= 1'b0;
                    r_wdog        <= '0;
                end
                default: begin
                    r_state       <= IDLE;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_grant_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        int'(r_grant_idx) < NUM_MASTERS);
`endif

endmodule
